// File: rtl/rvmyth_sar_adc_ctrl.sv
// SAR ADC controller: sample/hold, binary search through a reference DAC, registered result with valid pulse.
// Optional macro SAR_AVG4_EN: each start runs 4 conversions and reports their truncated mean.
module rvmyth_sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             comp,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  localparam int unsigned P       = SETTLE_CYCLES + 1;
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > P) ? SAMPLE_CYCLES : P;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    PHASE_LOAD  = CW'(P - 1);
  localparam logic [WIDTH-1:0] MSB         = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             sample_en_q, sample_en_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] resolved;
`ifdef SAR_AVG4_EN
  logic [1:0]       conv_q, conv_d;
  logic [WIDTH+1:0] acc_q, acc_d, acc_sum;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    sample_en_d  = sample_en_q;
    dac_code_d   = dac_code_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overrun_d    = 1'b0;
    // mask_q marks the bit under trial; comp decides whether it survives
    resolved     = comp ? dac_code_q : (dac_code_q & ~mask_q);
`ifdef SAR_AVG4_EN
    conv_d  = conv_q;
    acc_d   = acc_q;
    acc_sum = acc_q + (WIDTH+2)'(resolved);
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d    = IDLE;
        dac_code_d = '0;
        if (start) begin
          state_d     = SAMPLE;
          cnt_d       = SAMPLE_LOAD;
          sample_en_d = 1'b1;
          busy_d      = 1'b1;
`ifdef SAR_AVG4_EN
          conv_d = '0;
          acc_d  = '0;
`endif
        end
      end
      SAMPLE: begin
        overrun_d = start;
        if (cnt_q == '0) begin
          state_d     = CONVERT;
          cnt_d       = PHASE_LOAD;
          mask_d      = MSB;
          dac_code_d  = MSB;
          sample_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CONVERT: begin
        overrun_d = start;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!mask_q[0]) begin
          mask_d     = mask_q >> 1;
          dac_code_d = resolved | (mask_q >> 1);
          cnt_d      = PHASE_LOAD;
        end else begin
`ifdef SAR_AVG4_EN
          acc_d = acc_sum;
          if (conv_q != 2'd3) begin
            // Chain straight into the next sample; busy stays high throughout
            conv_d      = conv_q + 2'd1;
            state_d     = SAMPLE;
            cnt_d       = SAMPLE_LOAD;
            sample_en_d = 1'b1;
            dac_code_d  = '0;
          end else begin
            state_d      = DONE;
            data_out_d   = acc_sum[WIDTH+1:2];
            dac_code_d   = acc_sum[WIDTH+1:2];
            data_valid_d = 1'b1;
            busy_d       = 1'b0;
          end
`else
          state_d      = DONE;
          data_out_d   = resolved;
          dac_code_d   = resolved;
          data_valid_d = 1'b1;
          busy_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      sample_en_q  <= 1'b0;
      dac_code_q   <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SAR_AVG4_EN
      conv_q       <= '0;
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      sample_en_q  <= sample_en_d;
      dac_code_q   <= dac_code_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
`ifdef SAR_AVG4_EN
      conv_q       <= conv_d;
      acc_q        <= acc_d;
`endif
    end
  end

  assign sample_en  = sample_en_q;
  assign dac_code   = dac_code_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rvmyth_sar_adc_ctrl.sv
// Directed bench for rvmyth_sar_adc_ctrl: comparator model, scoreboard of expected results and valid cycles.
module tb_rvmyth_sar_adc_ctrl;
  localparam int W    = 10;
  localparam int S    = 4;
  localparam int P    = 2;
  localparam int CONV = S + W * P;

  logic         clk = 1'b0;
  logic         reset, start, comp;
  logic         sample_en, busy, data_valid, overrun;
  logic [W-1:0] dac_code, data_out;

  int vin;
  int cmode;  // 0: compare vin with dac_code, 1: comp tied 1, 2: comp tied 0

  assign comp = (cmode == 1) || ((cmode == 0) && (vin >= int'(dac_code)));

  rvmyth_sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .comp(comp),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy),
    .data_out(data_out), .data_valid(data_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int cyc; } exp_t;
  exp_t sbq[$];
  int   drv[$], accs[$], ovr[$];
  int   rel;
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, rel);
    end
  endtask

  function automatic int eff_vin();
    return (cmode == 1) ? 1023 : (cmode == 2) ? 0 : vin;
  endfunction

  // Trial code presented while bit b is under test
  function automatic int trial(input int v, input int b);
    int c = 0;
    for (int i = W - 1; i > b; i--)
      if (v >= (c | (1 << i))) c = c | (1 << i);
    return c | (1 << b);
  endfunction

  function automatic int final_code(input int v);
    int c = 0;
    for (int i = W - 1; i >= 0; i--)
      if (v >= (c | (1 << i))) c = c | (1 << i);
    return c;
  endfunction

  function automatic bit in_list(input int q[$], input int x);
    foreach (q[i]) if (q[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic begin_scn();
    rel = 0;
    drv.delete(); accs.delete(); ovr.delete(); sbq.delete();
  endtask

  task automatic step();
    int exp_se, exp_busy, exp_dac, s;
    start = in_list(drv, rel);
    @(posedge clk); #1;
    rel++;
    exp_se = 0; exp_busy = 0; exp_dac = 0;
    foreach (accs[k]) begin
      s = accs[k];
      if (rel >= s + 1 && rel <= s + S) exp_se = 1;
      if (rel >= s + 1 && rel <= s + CONV) exp_busy = 1;
      if (rel >= s + S + 1 && rel <= s + CONV)
        exp_dac = trial(eff_vin(), W - 1 - (rel - s - S - 1) / P);
      if (rel == s + CONV + 1) exp_dac = final_code(eff_vin());
    end
    check("sample_en", sample_en, exp_se);
    check("busy", busy, exp_busy);
    check("dac_code", dac_code, exp_dac);
    check("overrun", overrun, in_list(ovr, rel - 1));
    if (sbq.size() != 0 && sbq[0].cyc == rel) begin
      exp_t e = sbq.pop_front();
      check("data_valid", data_valid, 1);
      check("data_out", data_out, e.code);
    end else begin
      check("data_valid_idle", data_valid, 0);
    end
  endtask

  task automatic run_to(input int last);
    while (rel < last) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample_en"}, sample_en, 0);
    check({tag, "_dac_code"}, dac_code, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic single_conv(input int cm, input int v, input int result);
    begin_scn();
    cmode = cm; vin = v;
    drv.push_back(0); accs.push_back(0);
    sbq.push_back('{result, 1 + CONV});
    run_to(CONV + 6);
    check("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmode = 0; vin = 0; rel = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");
    begin_scn();
    run_to(10);

`ifdef SAR_AVG4_EN
    begin_scn();
    cmode = 0;
    for (int c = 0; c < 102; c++) begin
      start = (rel == 0);
      vin = (rel == 0) ? 100 : 100 + (((rel - 1) / CONV > 3) ? 3 : (rel - 1) / CONV);
      @(posedge clk); #1;
      rel++;
      check("avg_busy", busy, (rel >= 1 && rel <= 4 * CONV));
      check("avg_data_valid", data_valid, (rel == 4 * CONV + 1));
      if (rel == 4 * CONV + 1) check("avg_data_out", data_out, 101);
    end
`else
    single_conv(0, 612, 612);
    single_conv(1, 0, 1023);
    single_conv(2, 0, 0);

    // Overrun during conversion, then start in DONE chains a second conversion
    begin_scn();
    cmode = 0; vin = 612;
    drv = '{0, 10, 25}; accs = '{0, 25}; ovr = '{10};
    sbq.push_back('{612, 25});
    sbq.push_back('{612, 50});
    run_to(56);
    check("b2b_drained", sbq.size(), 0);

    // Reset mid-conversion aborts without a valid pulse
    begin_scn();
    cmode = 0; vin = 612;
    drv.push_back(0); accs.push_back(0);
    run_to(12);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rel++;
    reset = 1'b0;
    check_all_zero("abort");
    accs.delete(); drv.delete();
    run_to(45);

    single_conv(0, 612, 612);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
